// File: rtl/text_console_if.sv
// ---------------------------------------------------------------------------
// text_console_if
//   Host-side bus of the text console: direct cell writes, the putc character
//   stream with its ready handshake, the stream-attribute load and the busy
//   flag of the clear engine.
//
//   Parameters : COLS, ROWS  - console geometry (sets wr_row / wr_col widths)
//   Signals    : wr_en, wr_row, wr_col, wr_data       direct cell write
//                putc_valid, putc_ready, putc_data    character stream
//                attr_we, attr_in                     stream attribute load
//                busy                                 clear engine running
//   Modports   : master - the host that feeds the console
//                slave  - the console itself
// ---------------------------------------------------------------------------
interface text_console_if #(
   parameter int COLS = 80,
   parameter int ROWS = 45
);
   localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

   logic             wr_en;
   logic [ROW_W-1:0] wr_row;
   logic [COL_W-1:0] wr_col;
   logic [15:0]      wr_data;
   logic             putc_valid;
   logic             putc_ready;
   logic [7:0]       putc_data;
   logic             attr_we;
   logic [7:0]       attr_in;
   logic             busy;

   modport master (
      output wr_en, wr_row, wr_col, wr_data,
      output putc_valid, putc_data, attr_we, attr_in,
      input  putc_ready, busy
   );

   modport slave (
      input  wr_en, wr_row, wr_col, wr_data,
      input  putc_valid, putc_data, attr_we, attr_in,
      output putc_ready, busy
   );
endinterface

// File: rtl/text_console.sv
// ---------------------------------------------------------------------------
// text_console
//   Character-cell text console renderer. A COLS x ROWS RAM of 16-bit cells
//   {attr, char} is filled by direct writes or by a terminal-style putc stream
//   (cursor, CR/LF/BS, auto-wrap, hardware scroll) and rendered to 24-bit RGB
//   for the HDMI core through an external 8x16 glyph ROM and the CGA palette.
//
//   Ports:
//     clk        pixel clock, the only clock
//     reset      synchronous, active-high
//     cx, cy     current pixel coordinates from the HDMI core
//     rgb        {R,G,B}, three clocks after cx/cy
//     font_addr  {char, glyph_row} to the glyph ROM
//     font_row   glyph ROM data one clock after font_addr, bit 7 leftmost
//     bus        text_console_if.slave host bus (writes, putc, attr, busy)
//
//   Build option: define TEXT_CONSOLE_CURSOR_EN to draw a blinking underline
//   cursor on glyph rows 14..15 of the cursor cell.
// ---------------------------------------------------------------------------
module text_console #(
   parameter int         COLS     = 80,
   parameter int         ROWS     = 45,
   parameter int         CX_W     = 11,
   parameter int         CY_W     = 10,
   parameter logic [7:0] DEF_ATTR = 8'h0F
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [CX_W-1:0]   cx,
   input  logic [CY_W-1:0]   cy,
   output logic [23:0]       rgb,
   output logic [11:0]       font_addr,
   input  logic [7:0]        font_row,
   text_console_if.slave     bus
);

   localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CELLS  = COLS * ROWS;
   localparam int ADDR_W = (CELLS > 1) ? $clog2(CELLS) : 1;

   localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
   localparam logic [ROW_W:0]    ROWS_X    = (ROW_W + 1)'(ROWS);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(CELLS - 1);
   localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
   localparam logic [CX_W:0]     X_END     = (CX_W + 1)'(COLS * 8);
   localparam logic [CY_W:0]     Y_END     = (CY_W + 1)'(ROWS * 16);
   localparam logic [15:0]       CLR_CELL  = {DEF_ATTR, 8'h20};

   typedef enum logic [1:0] {
      CLR_ALL = 2'd0,
      IDLE    = 2'd1,
      CLR_ROW = 2'd2
   } state_t;

   // Logical row -> RAM address. Both operands are below ROWS, so a single
   // compare-and-subtract is enough to wrap the scrolled row.
   function automatic logic [ADDR_W-1:0] cell_addr(
      input logic [ROW_W-1:0] lrow,
      input logic [ROW_W-1:0] scroll,
      input logic [COL_W-1:0] col
   );
      logic [ROW_W:0] sum;
      sum = {1'b0, lrow} + {1'b0, scroll};
      if (sum >= ROWS_X) begin
         sum = sum - ROWS_X;
      end else begin
         sum = sum;
      end
      return ADDR_W'(sum) * COLS_A + ADDR_W'(col);
   endfunction

   // Standard 16-colour CGA palette.
   function automatic logic [23:0] cga(input logic [3:0] idx);
      case (idx)
         4'h0:    return 24'h000000;
         4'h1:    return 24'h0000AA;
         4'h2:    return 24'h00AA00;
         4'h3:    return 24'h00AAAA;
         4'h4:    return 24'hAA0000;
         4'h5:    return 24'hAA00AA;
         4'h6:    return 24'hAA5500;
         4'h7:    return 24'hAAAAAA;
         4'h8:    return 24'h555555;
         4'h9:    return 24'h5555FF;
         4'hA:    return 24'h55FF55;
         4'hB:    return 24'h55FFFF;
         4'hC:    return 24'hFF5555;
         4'hD:    return 24'hFF55FF;
         4'hE:    return 24'hFFFF55;
         4'hF:    return 24'hFFFFFF;
         default: return 24'h000000;
      endcase
   endfunction

   // ---------------- stream / clear state ----------------
   state_t            state_r;
   logic              busy_r;
   logic [ROW_W-1:0]  row_r;
   logic [COL_W-1:0]  col_r;
   logic [ROW_W-1:0]  scroll_r;
   logic [7:0]        cur_attr_r;
   logic [ADDR_W-1:0] clr_addr_r;
   logic [COL_W-1:0]  clr_col_r;

   logic              putc_ready_s;
   logic              putc_acc_s;
   logic              printable_s;
   logic              advance_s;

   logic              we_s;
   logic [ADDR_W-1:0] wa_s;
   logic [15:0]       wd_s;

   logic [15:0]       mem_r [CELLS];

   assign putc_ready_s   = (state_r == IDLE) && !bus.wr_en && !reset;
   assign putc_acc_s     = putc_ready_s && bus.putc_valid;
   assign bus.putc_ready = putc_ready_s;
   assign bus.busy       = busy_r;

   // Decode the accepted stream byte: printable or control, and whether it
   // moves the cursor to the next line (LF, or a write into the last column).
   always_comb begin
      printable_s = 1'b0;
      advance_s   = 1'b0;
      if (putc_acc_s) begin
         printable_s = (bus.putc_data != 8'h0A) && (bus.putc_data != 8'h0D) &&
                       (bus.putc_data != 8'h08);
         advance_s   = (bus.putc_data == 8'h0A) || (printable_s && (col_r == COL_LAST));
      end else begin
         printable_s = 1'b0;
         advance_s   = 1'b0;
      end
   end

   // Single RAM write port: clear engine, then direct write, then putc.
   // A direct write while the clear engine runs is simply dropped.
   always_comb begin
      we_s = 1'b0;
      wa_s = {ADDR_W{1'b0}};
      wd_s = 16'h0000;
      if (reset) begin
         we_s = 1'b0;
      end else if (state_r == CLR_ALL) begin
         we_s = 1'b1;
         wa_s = clr_addr_r;
         wd_s = CLR_CELL;
      end else if (state_r == CLR_ROW) begin
         we_s = 1'b1;
         wa_s = cell_addr(ROW_LAST, scroll_r, clr_col_r);
         wd_s = {cur_attr_r, 8'h20};
      end else if (bus.wr_en) begin
         we_s = 1'b1;
         wa_s = cell_addr(bus.wr_row, scroll_r, bus.wr_col);
         wd_s = bus.wr_data;
      end else if (printable_s) begin
         we_s = 1'b1;
         wa_s = cell_addr(row_r, scroll_r, col_r);
         wd_s = {cur_attr_r, bus.putc_data};
      end else begin
         we_s = 1'b0;
      end
   end

   // Cell RAM write port.
   always_ff @(posedge clk) begin
      if (we_s) begin
         mem_r[wa_s] <= wd_s;
      end
   end

   // Stream FSM: full clear after reset, cursor handling, scroll + row clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= CLR_ALL;
         busy_r     <= 1'b1;
         row_r      <= {ROW_W{1'b0}};
         col_r      <= {COL_W{1'b0}};
         scroll_r   <= {ROW_W{1'b0}};
         cur_attr_r <= DEF_ATTR;
         clr_addr_r <= {ADDR_W{1'b0}};
         clr_col_r  <= {COL_W{1'b0}};
      end else begin
         // The putc accepted in this cycle already latched the old attribute
         // on the write port, so loading here keeps the old-attr semantics.
         if (bus.attr_we) begin
            cur_attr_r <= bus.attr_in;
         end
         case (state_r)
            CLR_ALL: begin
               if (clr_addr_r == ADDR_LAST) begin
                  state_r    <= IDLE;
                  busy_r     <= 1'b0;
                  clr_addr_r <= {ADDR_W{1'b0}};
               end else begin
                  clr_addr_r <= clr_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
               end
            end
            CLR_ROW: begin
               if (clr_col_r == COL_LAST) begin
                  state_r   <= IDLE;
                  busy_r    <= 1'b0;
                  clr_col_r <= {COL_W{1'b0}};
               end else begin
                  clr_col_r <= clr_col_r + {{(COL_W-1){1'b0}}, 1'b1};
               end
            end
            IDLE: begin
               if (putc_acc_s) begin
                  case (bus.putc_data)
                     8'h0A, 8'h0D: col_r <= {COL_W{1'b0}};
                     8'h08: begin
                        if (col_r != {COL_W{1'b0}}) begin
                           col_r <= col_r - {{(COL_W-1){1'b0}}, 1'b1};
                        end
                     end
                     default: begin
                        if (col_r == COL_LAST) begin
                           col_r <= {COL_W{1'b0}};
                        end else begin
                           col_r <= col_r + {{(COL_W-1){1'b0}}, 1'b1};
                        end
                     end
                  endcase
               end
               if (advance_s) begin
                  if (row_r != ROW_LAST) begin
                     row_r <= row_r + {{(ROW_W-1){1'b0}}, 1'b1};
                  end else begin
                     // Bottom line: rotate the physical rows instead of moving
                     // data; the old top row becomes the new bottom and is cleared.
                     scroll_r  <= (scroll_r == ROW_LAST) ? {ROW_W{1'b0}}
                                  : scroll_r + {{(ROW_W-1){1'b0}}, 1'b1};
                     state_r   <= CLR_ROW;
                     busy_r    <= 1'b1;
                     clr_col_r <= {COL_W{1'b0}};
                  end
               end
            end
            default: begin
               state_r    <= CLR_ALL;
               busy_r     <= 1'b1;
               clr_addr_r <= {ADDR_W{1'b0}};
            end
         endcase
      end
   end

   // ---------------- render pipeline ----------------
   logic              active_s;
   logic [COL_W-1:0]  cell_col_s;
   logic [ROW_W-1:0]  cell_row_s;
   logic [ADDR_W-1:0] rd_addr_s;

   logic [15:0]       rd_data_r;
   logic              s1_valid_r;
   logic [3:0]        s1_grow_r;
   logic [2:0]        s1_bit_r;
   logic              s2_valid_r;
   logic [2:0]        s2_bit_r;
   logic [7:0]        attr_r;
   logic [23:0]       rgb_r;
   logic              cursor_on_s;
   logic              pixel_s;
   logic [23:0]       rgb_next_s;

   // S0: cell lookup. Off-screen pixels read address 0 so the RAM index
   // always stays in range; their colour is masked later.
   always_comb begin
      active_s   = ({1'b0, cx} < X_END) && ({1'b0, cy} < Y_END);
      cell_col_s = COL_W'(cx >> 3);
      cell_row_s = ROW_W'(cy >> 4);
      if (active_s) begin
         rd_addr_s = cell_addr(cell_row_s, scroll_r, cell_col_s);
      end else begin
         rd_addr_s = {ADDR_W{1'b0}};
      end
   end

   // S0 -> S1 -> S2 pipeline registers, including the RAM read register.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data_r  <= 16'h0000;
         s1_valid_r <= 1'b0;
         s1_grow_r  <= 4'h0;
         s1_bit_r   <= 3'd0;
         s2_valid_r <= 1'b0;
         s2_bit_r   <= 3'd0;
         attr_r     <= 8'h00;
      end else begin
         rd_data_r  <= mem_r[rd_addr_s];
         s1_valid_r <= active_s;
         s1_grow_r  <= cy[3:0];
         s1_bit_r   <= cx[2:0];
         s2_valid_r <= s1_valid_r;
         s2_bit_r   <= s1_bit_r;
         attr_r     <= rd_data_r[15:8];
      end
   end

   // Glyph ROM address straight from registers: the ROM answers in time for S2.
   assign font_addr = {rd_data_r[7:0], s1_grow_r};

`ifdef TEXT_CONSOLE_CURSOR_EN
   logic [4:0] blink_r;
   logic       cur_hit_s;
   logic       s1_cur_r;
   logic       s2_cur_r;

   assign cur_hit_s = active_s && (cell_row_s == row_r) && (cell_col_s == col_r) &&
                      (cy[3:1] == 3'b111);

   // Frame counter (bit 4 is the blink phase) and cursor-hit pipeline.
   always_ff @(posedge clk) begin
      if (reset) begin
         blink_r  <= 5'd0;
         s1_cur_r <= 1'b0;
         s2_cur_r <= 1'b0;
      end else begin
         if ((cx == {CX_W{1'b0}}) && (cy == {CY_W{1'b0}})) begin
            blink_r <= blink_r + 5'd1;
         end
         s1_cur_r <= cur_hit_s;
         s2_cur_r <= s1_cur_r;
      end
   end

   assign cursor_on_s = blink_r[4] && s2_cur_r;
`else
   assign cursor_on_s = 1'b0;
`endif

   // S2: pick the glyph bit and colour it.
   always_comb begin
      pixel_s    = font_row[3'd7 - s2_bit_r];
      rgb_next_s = 24'h000000;
      if (!s2_valid_r) begin
         rgb_next_s = 24'h000000;
      end else if (cursor_on_s) begin
         rgb_next_s = cga(cur_attr_r[3:0]);
      end else if (pixel_s) begin
         rgb_next_s = cga(attr_r[3:0]);
      end else begin
         rgb_next_s = cga(attr_r[7:4]);
      end
   end

   // Registered RGB output.
   always_ff @(posedge clk) begin
      if (reset) begin
         rgb_r <= 24'h000000;
      end else begin
         rgb_r <= rgb_next_s;
      end
   end

   assign rgb = rgb_r;

endmodule
